// File: rtl/fdiv_iter.sv
// fdiv_iter: multi-cycle restoring floating-point divider / reciprocal.
// One quotient bit per cycle, round-to-nearest-even, valid/ready on both sides.
module fdiv_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [EXP_W+MAN_W:0]   src_a,
    input  logic [EXP_W+MAN_W:0]   src_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   dest,
    output logic                   ovf,
    output logic                   udf
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(MAN_W + 2);
    localparam logic [EXP_W-1:0] BIAS = EXP_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0] ONE = {1'b0, BIAS, {MAN_W{1'b0}}};
    localparam logic [CW-1:0] LAST = CW'(MAN_W + 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [2:0] {IDLE, PREP, DIV, ROUND, DONE} state_t;

    state_t                 r_state, w_next;
    logic [W-1:0]           r_a, r_b, r_dest;
    logic                   r_sign, r_za, r_zb, r_ovf, r_udf;
    logic signed [EW-1:0]   r_e;
    logic [MAN_W+1:0]       r_rem;
    logic [MAN_W:0]         r_mb;
    logic [MAN_W:0]         r_q;
    logic [CW-1:0]          r_cnt;

    logic [EXP_W-1:0]       w_ea, w_eb;
    logic [MAN_W:0]         w_ma, w_mb, w_sub;
    logic                   w_lt, w_ge, w_up, w_cy, w_big, w_small;
    logic signed [EW-1:0]   w_e0, w_er;
    logic [MAN_W-1:0]       w_frac;
    logic [W-1:0]           w_inf, w_zero, w_res;

    assign w_ea = r_a[W-2:MAN_W];
    assign w_eb = r_b[W-2:MAN_W];
    assign w_ma = {1'b1, r_a[MAN_W-1:0]};
    assign w_mb = {1'b1, r_b[MAN_W-1:0]};
    assign w_lt = w_ma < w_mb;
    // Normalising the dividend up front keeps the quotient in [1,2).
    assign w_e0 = EW'(w_ea) - EW'(w_eb) + EW'(BIAS) - EW'(w_lt);

    assign w_ge  = r_rem >= {1'b0, r_mb};
    assign w_sub = w_ge ? (MAN_W+1)'(r_rem - {1'b0, r_mb}) : r_rem[MAN_W:0];

    // The integer quotient bit is always 1 and has already been shifted out of r_q.
    assign w_up    = r_q[0] & ((|r_rem) | r_q[1]);
    assign w_cy    = w_up & (&r_q[MAN_W:1]);
    assign w_frac  = r_q[MAN_W:1] + MAN_W'(w_up);
    assign w_er    = r_e + EW'(w_cy);
    assign w_big   = w_er >= EMAX;
    assign w_small = w_er[EW-1] | (w_er == '0);
    assign w_inf   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign w_zero  = {r_sign, {(W-1){1'b0}}};
    assign w_res   = r_zb ? w_inf : r_za ? w_zero : w_big ? w_inf : w_small ? w_zero
                   : {r_sign, w_er[EXP_W-1:0], w_frac};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? PREP : IDLE;
            PREP:    w_next = DIV;
            DIV:     w_next = (r_cnt == LAST) ? ROUND : DIV;
            ROUND:   w_next = DONE;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sign <= 1'b0;
            r_e    <= '0;
            r_rem  <= '0;
            r_mb   <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_za   <= 1'b0;
            r_zb   <= 1'b0;
            r_dest <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_a <= mode ? src_a : ONE;
                r_b <= src_b;
            end
            if (r_state == PREP) begin
                r_sign <= r_a[W-1] ^ r_b[W-1];
                r_e    <= w_e0;
                r_rem  <= w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
                r_mb   <= w_mb;
                r_q    <= '0;
                r_cnt  <= '0;
                r_za   <= w_ea == '0;
                r_zb   <= w_eb == '0;
            end
            if (r_state == DIV) begin
                r_rem <= {w_sub, 1'b0};
                r_q   <= {r_q[MAN_W-1:0], w_ge};
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
            end
            if (r_state == ROUND) begin
                r_dest <= w_res;
                r_ovf  <= r_zb | (~r_za & w_big);
                r_udf  <= ~r_zb & ~r_za & ~w_big & w_small;
            end
        end
    end

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    assign dest      = r_dest;
    assign ovf       = r_ovf;
    assign udf       = r_udf;
endmodule
